// File: rtl/sim_pkg.sv
// Shared definitions for the simulation phase sequencer and the node array.
package sim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VERLET,
        ST_CONSTRAINT,
        ST_SETTLE,
        ST_DONE
    } phase_state_t;

    localparam int DEF_CONSTRAINT_ITERS  = 4;
    localparam int DEF_CONSTRAINT_CYCLES = 2;
    localparam int DEF_SETTLE_CYCLES     = 1;
    localparam int POS_W                 = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that parks at zero and flags terminal count.
module phase_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         decrement,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (decrement && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/sim_phase_sequencer.sv
// Per-frame phase strobe generator: VERLET, constraint passes, settle, done.
module sim_phase_sequencer
    import sim_pkg::*;
#(
    parameter int CONSTRAINT_ITERS  = DEF_CONSTRAINT_ITERS,
    parameter int CONSTRAINT_CYCLES = DEF_CONSTRAINT_CYCLES,
    parameter int SETTLE_CYCLES     = DEF_SETTLE_CYCLES,
    parameter int ITER_W            = 3,
    parameter int FRAME_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               frame_tick,
    output logic               verlet_state,
    output logic               fix_constraint_state,
    output logic [ITER_W-1:0]  iter_idx,
    output logic               busy,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_count,
    output logic [7:0]         overrun_count
);

    localparam int CNT_MAX = max_int(CONSTRAINT_CYCLES, SETTLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  PASS_LOAD   = CNT_W'(CONSTRAINT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [ITER_W-1:0] ITER_LOAD   = ITER_W'(CONSTRAINT_ITERS - 1);

    phase_state_t       state_reg;
    logic               verlet_reg;
    logic               fix_reg;
    logic [ITER_W-1:0]  iter_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [FRAME_W-1:0] frame_count_reg;
    logic [7:0]         overrun_reg;

    logic tick_accept;
    logic cyc_tc, cyc_load, cyc_dec;
    logic pass_tc, pass_load, pass_dec;
    logic [CNT_W-1:0] cyc_value;

    assign tick_accept = enable && frame_tick;

    // The cycle counter is reused: in-pass length during CONSTRAINT, settle length afterwards.
    assign cyc_load  = (state_reg == ST_VERLET) || ((state_reg == ST_CONSTRAINT) && cyc_tc);
    assign cyc_value = ((state_reg == ST_CONSTRAINT) && pass_tc) ? SETTLE_LOAD : PASS_LOAD;
    assign cyc_dec   = (state_reg == ST_CONSTRAINT) || (state_reg == ST_SETTLE);
    assign pass_load = (state_reg == ST_VERLET);
    assign pass_dec  = (state_reg == ST_CONSTRAINT) && cyc_tc;

    phase_counter #(.W(CNT_W)) cycle_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cyc_load),
        .load_value (cyc_value),
        .decrement  (cyc_dec),
        .tc         (cyc_tc)
    );

    phase_counter #(.W(ITER_W)) pass_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (pass_load),
        .load_value (ITER_LOAD),
        .decrement  (pass_dec),
        .tc         (pass_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            verlet_reg      <= 1'b0;
            fix_reg         <= 1'b0;
            iter_reg        <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            frame_count_reg <= '0;
            overrun_reg     <= '0;
        end else begin
            // Ticks arriving mid-frame are dropped and counted, never queued.
            if (tick_accept && (state_reg != ST_IDLE) && (overrun_reg != 8'hFF)) begin
                overrun_reg <= overrun_reg + 8'd1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (tick_accept) begin
                        state_reg  <= ST_VERLET;
                        verlet_reg <= 1'b1;
                        busy_reg   <= 1'b1;
                    end
                end
                ST_VERLET: begin
                    state_reg  <= ST_CONSTRAINT;
                    verlet_reg <= 1'b0;
                    fix_reg    <= 1'b1;
                    iter_reg   <= '0;
                end
                ST_CONSTRAINT: begin
                    if (cyc_tc) begin
                        if (pass_tc) begin
                            fix_reg  <= 1'b0;
                            iter_reg <= '0;
                            if (SETTLE_CYCLES > 0) begin
                                state_reg <= ST_SETTLE;
                            end else begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            iter_reg <= iter_reg + ITER_W'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cyc_tc) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg       <= ST_IDLE;
                    done_reg        <= 1'b0;
                    busy_reg        <= 1'b0;
                    frame_count_reg <= frame_count_reg + FRAME_W'(1);
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign verlet_state         = verlet_reg;
    assign fix_constraint_state = fix_reg;
    assign iter_idx             = iter_reg;
    assign busy                 = busy_reg;
    assign frame_done           = done_reg;
    assign frame_count          = frame_count_reg;
    assign overrun_count        = overrun_reg;

endmodule

// File: tb/tb_sim_phase_sequencer.sv
// Bench for sim_phase_sequencer: default instance plus a minimal-latency instance.
module tb_sim_phase_sequencer;

    typedef struct {
        logic verlet;
        logic fix;
        int   iter;
        logic busy;
        logic done;
        int   fc;
        int   ov;
    } exp_t;

    typedef struct {
        logic       tick;
        logic       verlet;
        logic       fix;
        logic [2:0] iter;
        logic       busy;
        logic       done;
        int         fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, en_a, tick_a, rst_b, en_b, tick_b;
    logic       va, fa, ba, da;
    logic [2:0] ia;
    logic [15:0] fca;
    logic [7:0] oa;
    logic       vb, fb, bb, db;
    logic [0:0] ib;
    logic [3:0] fcb;
    logic [7:0] ob;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t xa, xb;
    int   m_pos[2];
    int   m_fc[2];
    int   m_ov[2];
    vec_t tbl[13];

    always #5 clk = ~clk;

    sim_phase_sequencer #(
        .CONSTRAINT_ITERS(4), .CONSTRAINT_CYCLES(2), .SETTLE_CYCLES(1),
        .ITER_W(3), .FRAME_W(16)
    ) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .frame_tick(tick_a),
        .verlet_state(va), .fix_constraint_state(fa), .iter_idx(ia),
        .busy(ba), .frame_done(da), .frame_count(fca), .overrun_count(oa)
    );

    sim_phase_sequencer #(
        .CONSTRAINT_ITERS(1), .CONSTRAINT_CYCLES(1), .SETTLE_CYCLES(0),
        .ITER_W(1), .FRAME_W(4)
    ) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .frame_tick(tick_b),
        .verlet_state(vb), .fix_constraint_state(fb), .iter_idx(ib),
        .busy(bb), .frame_done(db), .frame_count(fcb), .overrun_count(ob)
    );

    // Reference: position within the frame timeline (0 = idle, 1 = verlet, ... D = done).
    function automatic void model_step(input int id, input logic r, input logic e, input logic t,
                                       output exp_t x);
        int iters, cyc, settle, fw, d, p;
        iters  = (id == 0) ? 4 : 1;
        cyc    = (id == 0) ? 2 : 1;
        settle = (id == 0) ? 1 : 0;
        fw     = (id == 0) ? 16 : 4;
        d      = 2 + iters * cyc + settle;
        if (r) begin
            m_pos[id] = 0;
            m_fc[id]  = 0;
            m_ov[id]  = 0;
        end else begin
            if (e && t && m_pos[id] != 0 && m_ov[id] < 255) m_ov[id]++;
            if (m_pos[id] == 0) begin
                if (e && t) m_pos[id] = 1;
            end else if (m_pos[id] == d) begin
                m_pos[id] = 0;
                m_fc[id]  = (m_fc[id] + 1) % (1 << fw);
            end else begin
                m_pos[id]++;
            end
        end
        p        = m_pos[id];
        x.verlet = (p == 1);
        x.fix    = (p >= 2) && (p <= 1 + iters * cyc);
        x.iter   = x.fix ? (p - 2) / cyc : 0;
        x.busy   = (p != 0);
        x.done   = (p == d);
        x.fc     = m_fc[id];
        x.ov     = m_ov[id];
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic cmp(input string tag, input exp_t x, input logic v, input logic f, input int it,
                       input logic b, input logic d, input int fc, input int ov);
        n_checks++;
        if (v !== x.verlet || f !== x.fix || it != x.iter || b !== x.busy ||
            d !== x.done || fc != x.fc || ov != x.ov) begin
            n_errors++;
            $display("FAIL %s: got v=%0b f=%0b it=%0d b=%0b d=%0b fc=%0d ov=%0d expected v=%0b f=%0b it=%0d b=%0b d=%0b fc=%0d ov=%0d",
                     tag, v, f, it, b, d, fc, ov,
                     x.verlet, x.fix, x.iter, x.busy, x.done, x.fc, x.ov);
        end
    endtask

    // Drive both instances for one edge and queue what each should show after it.
    task automatic step(input logic ra, input logic ea, input logic ta,
                        input logic rb, input logic eb, input logic tb);
        exp_t x;
        @(negedge clk);
        rst_a = ra; en_a = ea; tick_a = ta;
        rst_b = rb; en_b = eb; tick_b = tb;
        model_step(0, ra, ea, ta, x);
        qa.push_back(x);
        model_step(1, rb, eb, tb, x);
        qb.push_back(x);
    endtask

    task automatic stepa(input logic r, input logic e, input logic t);
        step(r, e, t, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stepb(input logic r, input logic e, input logic t);
        step(1'b0, 1'b0, 1'b0, r, e, t);
    endtask

    task automatic settle_after_edge();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) begin
            xa = qa.pop_front();
            cmp("sb_a", xa, va, fa, int'(ia), ba, da, int'(fca), int'(oa));
        end
        if (qb.size() > 0) begin
            xb = qb.pop_front();
            cmp("sb_b", xb, vb, fb, int'(ib), bb, db, int'(fcb), int'(ob));
        end
    end

    always @(negedge clk) begin
        if (qa.size() > 0 || qb.size() > 0) begin
            chk("excl_a", int'(va & fa), 0);
            chk("excl_b", int'(vb & fb), 0);
        end
    end

    initial begin
        rst_a = 1'b0; en_a = 1'b0; tick_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b0; tick_b = 1'b0;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 0};
        for (int k = 1; k <= 8; k++) tbl[k] = '{1'b0, 1'b0, 1'b1, 3'((k - 1) / 2), 1'b1, 1'b0, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1};

        // Single frame latency against a fixed timeline
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        settle_after_edge();
        chk("reset_busy_a", int'(ba), 0);
        chk("reset_fc_a", int'(fca), 0);
        for (int k = 1; k < 10; k++) stepa(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 13; k++) begin
            stepa(1'b0, 1'b1, tbl[k].tick);
            settle_after_edge();
            chk($sformatf("t1_strobes_row%0d", k), int'({va, fa, ia, ba, da}),
                int'({tbl[k].verlet, tbl[k].fix, tbl[k].iter, tbl[k].busy, tbl[k].done}));
            chk($sformatf("t1_fc_row%0d", k), int'(fca), tbl[k].fc);
        end

        // Back-to-back ticks: mid-frame and DONE-cycle ticks are dropped
        stepa(1'b1, 1'b1, 1'b0);
        for (int k = 0; k <= 12; k++) stepa(1'b0, 1'b1, (k == 0 || k == 5 || k == 11 || k == 12));
        settle_after_edge();
        chk("t2_overrun", int'(oa), 2);
        chk("t2_fc", int'(fca), 1);
        chk("t2_second_verlet", int'(va), 1);
        for (int k = 0; k < 12; k++) stepa(1'b0, 1'b1, 1'b0);

        // Reset mid-CONSTRAINT aborts the frame
        stepa(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) stepa(1'b0, 1'b1, (k == 0));
        stepa(1'b1, 1'b1, 1'b0);
        settle_after_edge();
        chk("t3_abort_outputs", int'({va, fa, ia, ba, da}), 0);
        stepa(1'b0, 1'b1, 1'b0);
        stepa(1'b0, 1'b1, 1'b1);
        settle_after_edge();
        chk("t3_restart_verlet", int'(va), 1);
        for (int k = 0; k < 12; k++) stepa(1'b0, 1'b1, 1'b0);
        chk("t3_fc_after_restart", int'(fca), 1);

        // Disabled ticks are ignored entirely
        for (int k = 0; k < 50; k++) stepa(1'b0, 1'b0, 1'b1);
        settle_after_edge();
        chk("t4_busy", int'(ba), 0);
        chk("t4_overrun", int'(oa), 0);
        stepa(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) stepa(1'b0, 1'b1, 1'b0);
        settle_after_edge();
        chk("t4_fc", int'(fca), 2);

        // Minimal configuration latency and overrun saturation
        stepb(1'b1, 1'b1, 1'b0);
        stepb(1'b0, 1'b1, 1'b1);
        settle_after_edge();
        chk("t5_verlet", int'(vb), 1);
        stepb(1'b0, 1'b1, 1'b0);
        settle_after_edge();
        chk("t5_fix", int'(fb), 1);
        stepb(1'b0, 1'b1, 1'b0);
        settle_after_edge();
        chk("t5_done", int'(db), 1);
        for (int k = 0; k < 400; k++) stepb(1'b0, 1'b1, 1'b1);
        settle_after_edge();
        chk("t5_overrun_sat", int'(ob), 255);

        // Frame counter wrap (FRAME_W=4: 17 frames -> 1)
        stepb(1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 17; f++) begin
            stepb(1'b0, 1'b1, 1'b1);
            for (int k = 0; k < 3; k++) stepb(1'b0, 1'b1, 1'b0);
        end
        settle_after_edge();
        chk("t6_fc_wrap", int'(fcb), 1);

        stepa(1'b0, 1'b0, 1'b0);
        settle_after_edge();
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
